mgt_startup_sequencer: RTL and testbench

MGT_STARTUP_SEQUENCER -- requirements
Module: mgt_startup_sequencer

---
 rtl/mgt_startup_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_mgt_startup_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mgt_startup_sequencer.sv
// rtl/mgt_startup_sequencer.sv - PLL/MGT power-up reset sequencer with timeouts, retries and lock-loss recovery
//
// Ports:
//   clock_40         in   sole clock, rising edge
//   reset_i          in   synchronous active-high reset
//   pll_lock_i       in   PLL lock (asynchronous, resynchronized here)
//   tx_resetdone_i   in   MGT TX reset done (asynchronous, resynchronized here)
//   restart_i        in   one-cycle restart request, highest priority after reset
//   pll_reset_o      out  PLL reset
//   mgt_reset_o      out  per-lane MGT reset, all lanes identical
//   startup_done_o   out  link ready (feeds mgt_startup_done of mgt_control_tmr)
//   fault_o          out  retries exhausted, sticky until restart
//   state_o          out  current state code
//   retry_cnt_o      out  failed attempts in the current sequence
//   lock_loss_cnt_o  out  saturating count of lock losses seen in DONE
//
// Cycle parameters are legal in 1..65535, MAX_RETRIES in 1..15.

module mgt_startup_sequencer #(
    parameter int PLL_RESET_CYCLES = 8,
    parameter int LOCK_TIMEOUT     = 1024,
    parameter int MGT_RESET_CYCLES = 8,
    parameter int DONE_TIMEOUT     = 1024,
    parameter int SETTLE_CYCLES    = 64,
    parameter int MAX_RETRIES      = 3
) (
    input  logic       clock_40,
    input  logic       reset_i,
    input  logic       pll_lock_i,
    input  logic       tx_resetdone_i,
    input  logic       restart_i,
    output logic       pll_reset_o,
    output logic [3:0] mgt_reset_o,
    output logic       startup_done_o,
    output logic       fault_o,
    output logic [2:0] state_o,
    output logic [3:0] retry_cnt_o,
    output logic [7:0] lock_loss_cnt_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLL_RESET = 3'd1,
        WAIT_LOCK = 3'd2,
        MGT_RESET = 3'd3,
        WAIT_DONE = 3'd4,
        SETTLE    = 3'd5,
        DONE      = 3'd6,
        FAULT     = 3'd7
    } state_t;

    // Terminal counter values: a state timed for N cycles leaves when the
    // counter shows N-1.
    localparam logic [15:0] PLL_LAST    = 16'(PLL_RESET_CYCLES - 1);
    localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] MGT_LAST    = 16'(MGT_RESET_CYCLES - 1);
    localparam logic [15:0] DONE_LAST   = 16'(DONE_TIMEOUT - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_LAST  = 4'(MAX_RETRIES - 1);

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic [3:0]  retry_cnt;
    logic [3:0]  retry_next;
    logic [7:0]  loss_cnt;
    logic [7:0]  loss_next;
    logic        entering;
    logic        fail;

    logic        lock_meta;
    logic        lock;
    logic        rdone_meta;
    logic        rdone;

    // Two-flop synchronizers for the asynchronous status inputs.
    always_ff @(posedge clock_40) begin
        if (reset_i) begin
            lock_meta  <= 1'b0;
            lock       <= 1'b0;
            rdone_meta <= 1'b0;
            rdone      <= 1'b0;
        end else begin
            lock_meta  <= pll_lock_i;
            lock       <= lock_meta;
            rdone_meta <= tx_resetdone_i;
            rdone      <= rdone_meta;
        end
    end

    always_comb begin
        next_state = state;
        retry_next = retry_cnt;
        loss_next  = loss_cnt;
        fail       = 1'b0;

        case (state)
            IDLE: begin
                next_state = PLL_RESET;
            end
            PLL_RESET: begin
                if (cnt == PLL_LAST) begin
                    next_state = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock) begin
                    next_state = MGT_RESET;
                end else if (cnt == LOCK_LAST) begin
                    fail = 1'b1;
                end
            end
            MGT_RESET: begin
                if (cnt == MGT_LAST) begin
                    next_state = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (rdone) begin
                    next_state = SETTLE;
                end else if (cnt == DONE_LAST) begin
                    fail = 1'b1;
                end
            end
            SETTLE: begin
                // Any dropout while settling aborts the attempt.
                if (!lock || !rdone) begin
                    fail = 1'b1;
                end else if (cnt == SETTLE_LAST) begin
                    next_state = DONE;
                    retry_next = 4'd0;
                end
            end
            DONE: begin
                // Lock loss restarts the PLL without consuming a retry;
                // losing only reset-done just re-resets the transceiver.
                if (!lock) begin
                    next_state = PLL_RESET;
                    if (loss_cnt != 8'hFF) begin
                        loss_next = loss_cnt + 8'd1;
                    end
                end else if (!rdone) begin
                    next_state = MGT_RESET;
                end
            end
            FAULT: begin
                next_state = FAULT;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        if (fail) begin
            if (retry_cnt == RETRY_LAST) begin
                next_state = FAULT;
            end else begin
                next_state = PLL_RESET;
                retry_next = retry_cnt + 4'd1;
            end
        end

        // Restart beats everything, including a coincident timeout or lock loss.
        if (restart_i) begin
            next_state = PLL_RESET;
            retry_next = 4'd0;
            loss_next  = loss_cnt;
        end
    end

    // A restart from PLL_RESET re-enters the same state, so it must also
    // clear the counter.
    assign entering = (next_state != state) || restart_i;

    always_ff @(posedge clock_40) begin
        if (reset_i) begin
            state     <= IDLE;
            cnt       <= 16'd0;
            retry_cnt <= 4'd0;
            loss_cnt  <= 8'd0;
        end else begin
            state     <= next_state;
            cnt       <= entering ? 16'd0 : cnt + 16'd1;
            retry_cnt <= retry_next;
            loss_cnt  <= loss_next;
        end
    end

    // Outputs are decoded from the next state and registered so they change
    // in the same cycle as state_o, with no combinational path to the pins.
    always_ff @(posedge clock_40) begin
        if (reset_i) begin
            pll_reset_o    <= 1'b1;
            mgt_reset_o    <= 4'hF;
            startup_done_o <= 1'b0;
            fault_o        <= 1'b0;
        end else begin
            pll_reset_o    <= (next_state == IDLE) || (next_state == PLL_RESET);
            mgt_reset_o    <= {4{(next_state == IDLE)      || (next_state == PLL_RESET) ||
                                 (next_state == WAIT_LOCK) || (next_state == MGT_RESET) ||
                                 (next_state == FAULT)}};
            startup_done_o <= (next_state == DONE);
            fault_o        <= (next_state == FAULT);
        end
    end

    assign state_o         = state;
    assign retry_cnt_o     = retry_cnt;
    assign lock_loss_cnt_o = loss_cnt;

endmodule

// File: tb/tb_mgt_startup_sequencer.sv
// tb/tb_mgt_startup_sequencer.sv - directed self-checking bench for mgt_startup_sequencer

module tb_mgt_startup_sequencer;

    logic       clock_40 = 1'b0;
    logic       reset_i;
    logic       pll_lock_i;
    logic       tx_resetdone_i;
    logic       restart_i;
    logic       pll_reset_o;
    logic [3:0] mgt_reset_o;
    logic       startup_done_o;
    logic       fault_o;
    logic [2:0] state_o;
    logic [3:0] retry_cnt_o;
    logic [7:0] lock_loss_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clock_40 = ~clock_40;

    mgt_startup_sequencer dut (
        .clock_40        (clock_40),
        .reset_i         (reset_i),
        .pll_lock_i      (pll_lock_i),
        .tx_resetdone_i  (tx_resetdone_i),
        .restart_i       (restart_i),
        .pll_reset_o     (pll_reset_o),
        .mgt_reset_o     (mgt_reset_o),
        .startup_done_o  (startup_done_o),
        .fault_o         (fault_o),
        .state_o         (state_o),
        .retry_cnt_o     (retry_cnt_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clock_40);
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int budget, output int cyc);
        cyc = 0;
        while (state_o !== s && cyc < budget) begin
            step(1);
            cyc++;
        end
        check(tag, 32'(state_o), 32'(s));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        check({tag, "_pll"},   32'(pll_reset_o), 32'd1);
        check({tag, "_mgt"},   32'(mgt_reset_o), 32'hF);
        check({tag, "_done"},  32'(startup_done_o), 32'd0);
        check({tag, "_fault"}, 32'(fault_o), 32'd0);
        check({tag, "_retry"}, 32'(retry_cnt_o), 32'd0);
        check({tag, "_loss"},  32'(lock_loss_cnt_o), 32'd0);
    endtask

    initial begin
        int cyc;
        int n;
        logic done_seen;

        reset_i        = 1'b1;
        pll_lock_i     = 1'b1;
        tx_resetdone_i = 1'b1;
        restart_i      = 1'b0;
        step(3);
        check_reset_outputs("reset");

        // Nominal bring-up with both status inputs tied high.
        reset_i = 1'b0;
        n = 1;
        step(1);
        check("idle_to_pll_reset", 32'(state_o), 32'd1);
        while (pll_reset_o && n < 50) begin
            n++;
            step(1);
        end
        check("pll_reset_high_cycles", 32'(n), 32'd9);
        wait_state("reach_wait_done", 3'd4, 50, cyc);
        check("mgt_reset_low_wait_done", 32'(mgt_reset_o), 32'd0);
        wait_state("reach_settle", 3'd5, 50, cyc);
        n = 0;
        while (!startup_done_o && n < 200) begin
            step(1);
            n++;
        end
        check("settle_to_done_cycles", 32'(n), 32'd64);
        check("nominal_state", 32'(state_o), 32'd6);
        check("nominal_retry", 32'(retry_cnt_o), 32'd0);

        // Lock loss in DONE for 5 cycles.
        pll_lock_i = 1'b0;
        step(2);
        check("lockloss_done_held", 32'(startup_done_o), 32'd1);
        step(1);
        check("lockloss_done_fell", 32'(startup_done_o), 32'd0);
        check("lockloss_state", 32'(state_o), 32'd1);
        check("lockloss_count", 32'(lock_loss_cnt_o), 32'd1);
        check("lockloss_retry", 32'(retry_cnt_o), 32'd0);
        step(2);
        pll_lock_i = 1'b1;
        wait_state("lockloss_redone", 3'd6, 500, cyc);
        check("lockloss_redone_done", 32'(startup_done_o), 32'd1);

        // Reset-done loss in DONE re-resets only the transceiver.
        tx_resetdone_i = 1'b0;
        step(1);
        tx_resetdone_i = 1'b1;
        wait_state("rdone_loss_mgt_reset", 3'd3, 10, cyc);
        check("rdone_loss_no_lockcount", 32'(lock_loss_cnt_o), 32'd1);
        check("rdone_loss_mgt_high", 32'(mgt_reset_o), 32'hF);
        wait_state("rdone_loss_redone", 3'd6, 500, cyc);

        // One-cycle reset-done glitch at SETTLE count 30.
        restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        check("restart_from_done", 32'(state_o), 32'd1);
        wait_state("glitch_settle", 3'd5, 200, cyc);
        step(29);
        tx_resetdone_i = 1'b0;
        step(1);
        tx_resetdone_i = 1'b1;
        done_seen = 1'b0;
        n = 0;
        while (state_o !== 3'd1 && n < 10) begin
            step(1);
            n++;
            if (startup_done_o) done_seen = 1'b1;
        end
        check("glitch_state", 32'(state_o), 32'd1);
        check("glitch_retry", 32'(retry_cnt_o), 32'd1);
        check("glitch_no_done", 32'(done_seen), 32'd0);

        // Permanent lock failure: three attempts of 8+1024 cycles, then FAULT.
        pll_lock_i = 1'b0;
        restart_i  = 1'b1;
        step(1);
        restart_i  = 1'b0;
        check("timeout_retry0", 32'(retry_cnt_o), 32'd0);
        n = 0;
        while (retry_cnt_o != 4'd1 && n < 3000) begin
            step(1);
            n++;
        end
        check("attempt1_cycles", 32'(n), 32'd1032);
        check("attempt1_state", 32'(state_o), 32'd1);
        n = 0;
        while (retry_cnt_o != 4'd2 && n < 3000) begin
            step(1);
            n++;
        end
        check("attempt2_cycles", 32'(n), 32'd1032);
        wait_state("fault_state", 3'd7, 1100, cyc);
        check("attempt3_cycles", 32'(cyc), 32'd1032);
        check("fault_flag", 32'(fault_o), 32'd1);
        check("fault_retry", 32'(retry_cnt_o), 32'd2);
        check("fault_mgt", 32'(mgt_reset_o), 32'hF);
        check("fault_pll", 32'(pll_reset_o), 32'd0);
        step(200);
        check("fault_sticky_state", 32'(state_o), 32'd7);
        check("fault_sticky_flag", 32'(fault_o), 32'd1);
        restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        check("fault_restart_state", 32'(state_o), 32'd1);
        check("fault_restart_retry", 32'(retry_cnt_o), 32'd0);
        check("fault_restart_flag", 32'(fault_o), 32'd0);

        // Restart coincident with the final WAIT_LOCK timeout.
        n = 0;
        while (retry_cnt_o != 4'd2 && n < 2500) begin
            step(1);
            n++;
        end
        check("simul_retry2", 32'(retry_cnt_o), 32'd2);
        step(8);
        check("simul_wait_lock", 32'(state_o), 32'd2);
        step(1023);
        check("simul_last_cycle", 32'(state_o), 32'd2);
        restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        check("simul_state", 32'(state_o), 32'd1);
        check("simul_retry", 32'(retry_cnt_o), 32'd0);
        check("simul_fault", 32'(fault_o), 32'd0);

        // Lock-loss counter saturation.
        pll_lock_i = 1'b1;
        wait_state("sat_first_done", 3'd6, 500, cyc);
        for (int i = 1; i <= 300; i++) begin
            pll_lock_i = 1'b0;
            step(1);
            pll_lock_i = 1'b1;
            step(2);
            wait_state("sat_redone", 3'd6, 500, cyc);
            if (i == 253) check("sat_count_254", 32'(lock_loss_cnt_o), 32'd254);
        end
        check("sat_count_255", 32'(lock_loss_cnt_o), 32'd255);

        // Reset mid-WAIT_DONE, coincident with restart.
        tx_resetdone_i = 1'b0;
        wait_state("pre_reset_wait_done", 3'd4, 100, cyc);
        step(5);
        reset_i   = 1'b1;
        restart_i = 1'b1;
        step(1);
        restart_i = 1'b0;
        check_reset_outputs("midreset");
        step(2);
        reset_i = 1'b0;
        check("post_reset_idle", 32'(state_o), 32'd0);
        step(1);
        check("post_reset_pll", 32'(state_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
